// File: rtl/tb_obi_pkg.sv
// Shared types for the two-master OBI data-port arbiter and its in-order ID tracker.
// Request/response structs are sized by the package widths that the arbiter defaults to.
package tb_obi_pkg;

    localparam int OBI_AW  = 32;
    localparam int OBI_DW  = 32;
    localparam int OBI_BEW = OBI_DW / 8;

    typedef struct packed {
        logic [OBI_AW-1:0]  addr;
        logic               we;
        logic [OBI_BEW-1:0] be;
        logic [OBI_DW-1:0]  wdata;
    } obi_req_t;

    typedef struct packed {
        logic [OBI_DW-1:0] rdata;
        logic              err;
    } obi_rsp_t;

    typedef enum logic {
        ARB  = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

    // With both masters requesting, the pointer side wins; otherwise the lone requester.
    function automatic logic rr_pick(input logic [1:0] req, input logic ptr);
        if (req[0] && req[1]) begin
            return ptr;
        end
        return req[1];
    endfunction

endpackage

// File: rtl/tb_id_fifo.sv
// Purpose: small in-order FIFO holding the issuing-master ID of each outstanding transaction.
// Latency: push/pop take effect on the clock edge; head data and flags are registered outputs.
// Backpressure: push ignored when full and pop ignored when empty, so count never wraps.
module tb_id_fifo #(
    parameter  int WIDTH = 1,
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_dat_o,
    output logic [CW-1:0]    count_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push_ok, pop_ok;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == CW'(DEPTH));
    assign count_o   = count_q;
    assign pop_dat_o = mem_q[rd_ptr_q];
    assign push_ok   = push_i && !full_o;
    assign pop_ok    = pop_i && !empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_dat_i;
                wr_ptr_q        <= next_ptr(wr_ptr_q);
            end
            if (pop_ok) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/tb_obi_data_arbiter.sv
// Purpose: round-robin share of the mm_ram data OBI port between core (m0) and agent (m1).
// Latency: zero added; request, grant and response paths are combinational.
// Backpressure: s_gnt_i low freezes the selected master; request blocked while MAX_OUTSTANDING are in flight.
module tb_obi_data_arbiter
    import tb_obi_pkg::*;
#(
    parameter  int ADDR_WIDTH      = OBI_AW,
    parameter  int DATA_WIDTH      = OBI_DW,
    parameter  int MAX_OUTSTANDING = 2,
    localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,

    input  logic                    m0_req_i,
    output logic                    m0_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
    input  logic                    m0_we_i,
    input  logic [DATA_WIDTH/8-1:0] m0_be_i,
    input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
    output logic                    m0_rvalid_o,
    output logic [DATA_WIDTH-1:0]   m0_rdata_o,
    output logic                    m0_err_o,

    input  logic                    m1_req_i,
    output logic                    m1_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
    input  logic                    m1_we_i,
    input  logic [DATA_WIDTH/8-1:0] m1_be_i,
    input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
    output logic                    m1_rvalid_o,
    output logic [DATA_WIDTH-1:0]   m1_rdata_o,
    output logic                    m1_err_o,

    output logic                    s_req_o,
    input  logic                    s_gnt_i,
    output logic [ADDR_WIDTH-1:0]   s_addr_o,
    output logic                    s_we_o,
    output logic [DATA_WIDTH/8-1:0] s_be_o,
    output logic [DATA_WIDTH-1:0]   s_wdata_o,
    input  logic                    s_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   s_rdata_i,
    input  logic                    s_err_i,

    output logic [CNT_W-1:0]        outstanding_o,
    output logic                    protocol_err_o
);

    arb_state_e     state_q, state_d;
    logic           hold_id_q, hold_id_d;
    logic           ptr_q, ptr_d;
    logic           perr_q, perr_d;

    obi_req_t [1:0] mreq;
    obi_req_t       s_dat;
    obi_rsp_t       rsp;
    logic [1:0]     req;
    logic           sel, s_req, accept;
    logic           fifo_empty, fifo_full, head_id, rsp_vld;

    assign req     = {m1_req_i, m0_req_i};
    assign mreq[0] = '{addr: m0_addr_i, we: m0_we_i, be: m0_be_i, wdata: m0_wdata_i};
    assign mreq[1] = '{addr: m1_addr_i, we: m1_we_i, be: m1_be_i, wdata: m1_wdata_i};
    assign rsp     = '{rdata: s_rdata_i, err: s_err_i};

    // Full blocks new requests even when a response frees a slot this cycle.
    always_comb begin
        state_d   = state_q;
        hold_id_d = hold_id_q;
        sel       = 1'b0;
        s_req     = 1'b0;
        case (state_q)
            ARB: begin
                if (!fifo_full) begin
                    sel   = rr_pick(req, ptr_q);
                    s_req = |req;
                    if (s_req && !s_gnt_i) begin
                        state_d   = HOLD;
                        hold_id_d = sel;
                    end
                end
            end
            HOLD: begin
                sel   = hold_id_q;
                s_req = req[hold_id_q] && !fifo_full;
                if (!s_req || s_gnt_i) begin
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
        accept = s_req && s_gnt_i;
        ptr_d  = accept ? ~sel : ptr_q;
        perr_d = perr_q | (s_rvalid_i & fifo_empty);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ARB;
            hold_id_q <= 1'b0;
            ptr_q     <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_id_q <= hold_id_d;
            ptr_q     <= ptr_d;
            perr_q    <= perr_d;
        end
    end

    tb_id_fifo #(
        .WIDTH (1),
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push_i     (accept),
        .push_dat_i (sel),
        .pop_i      (s_rvalid_i),
        .pop_dat_o  (head_id),
        .count_o    (outstanding_o),
        .empty_o    (fifo_empty),
        .full_o     (fifo_full)
    );

    assign s_dat          = s_req ? mreq[sel] : '0;
    assign s_req_o        = s_req;
    assign s_addr_o       = s_dat.addr;
    assign s_we_o         = s_dat.we;
    assign s_be_o         = s_dat.be;
    assign s_wdata_o      = s_dat.wdata;
    assign m0_gnt_o       = accept && !sel;
    assign m1_gnt_o       = accept && sel;

    // A response with nothing outstanding is dropped and only flagged.
    assign rsp_vld        = s_rvalid_i && !fifo_empty;
    assign m0_rvalid_o    = rsp_vld && !head_id;
    assign m1_rvalid_o    = rsp_vld && head_id;
    assign m0_rdata_o     = m0_rvalid_o ? rsp.rdata : '0;
    assign m1_rdata_o     = m1_rvalid_o ? rsp.rdata : '0;
    assign m0_err_o       = m0_rvalid_o && rsp.err;
    assign m1_err_o       = m1_rvalid_o && rsp.err;
    assign protocol_err_o = perr_q;

endmodule

// File: tb/tb_tb_obi_data_arbiter.sv
// Bench for the two-master OBI arbiter: directed cycle table, corner sequences, random run vs queue model.
module tb_tb_obi_data_arbiter;

    localparam int MAXO = 2;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        m0_req, m0_gnt, m0_we, m0_rvalid, m0_err;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_be;
    logic        m1_req, m1_gnt, m1_we, m1_rvalid, m1_err;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_be;
    logic        s_req, s_gnt, s_we, s_rvalid, s_err;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_be;
    logic [1:0]  outstanding;
    logic        perr;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tb_obi_data_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .m0_req_i(m0_req), .m0_gnt_o(m0_gnt), .m0_addr_i(m0_addr), .m0_we_i(m0_we),
        .m0_be_i(m0_be), .m0_wdata_i(m0_wdata), .m0_rvalid_o(m0_rvalid),
        .m0_rdata_o(m0_rdata), .m0_err_o(m0_err),
        .m1_req_i(m1_req), .m1_gnt_o(m1_gnt), .m1_addr_i(m1_addr), .m1_we_i(m1_we),
        .m1_be_i(m1_be), .m1_wdata_i(m1_wdata), .m1_rvalid_o(m1_rvalid),
        .m1_rdata_o(m1_rdata), .m1_err_o(m1_err),
        .s_req_o(s_req), .s_gnt_i(s_gnt), .s_addr_o(s_addr), .s_we_o(s_we),
        .s_be_o(s_be), .s_wdata_o(s_wdata), .s_rvalid_i(s_rvalid),
        .s_rdata_i(s_rdata), .s_err_i(s_err),
        .outstanding_o(outstanding), .protocol_err_o(perr)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          m0, m1, gnt, rv;
        bit          e_g0, e_g1, e_sreq;
        logic [31:0] e_addr;
        bit          e_rv0, e_rv1;
        int          e_out;
    } vec_t;

    function automatic vec_t mk(bit a, bit b, bit g, bit r, bit eg0, bit eg1, bit esr,
                                logic [31:0] ead, bit er0, bit er1, int eo);
        vec_t v;
        v.m0 = a; v.m1 = b; v.gnt = g; v.rv = r;
        v.e_g0 = eg0; v.e_g1 = eg1; v.e_sreq = esr; v.e_addr = ead;
        v.e_rv0 = er0; v.e_rv1 = er1; v.e_out = eo;
        return v;
    endfunction

    task automatic idle_inputs();
        m0_req = 0; m1_req = 0; s_gnt = 0; s_rvalid = 0; s_rdata = '0; s_err = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Random-phase model: in-order ID queue, RR pointer, and the master an unanswered request is pinned to.
    int q[$];
    int ptr_m, hold_m;
    bit perr_m;

    vec_t        tbl[21];
    bit          pend[2];
    logic [31:0] r_addr[2], r_wdata[2];
    logic        r_we[2];
    logic [3:0]  r_be[2];

    initial begin
        idle_inputs();
        m0_addr = 32'h100; m0_we = 0; m0_be = 4'hF; m0_wdata = 32'h0;
        m1_addr = 32'h200; m1_we = 1; m1_be = 4'h3; m1_wdata = 32'hDEAD0000;
        rst_ni = 0;
        #12;
        chk("rst.s_req", s_req, 0);
        chk("rst.g0", m0_gnt, 0);
        chk("rst.g1", m1_gnt, 0);
        chk("rst.rv0", m0_rvalid, 0);
        chk("rst.s_addr", s_addr, 0);
        chk("rst.outstanding", outstanding, 0);
        chk("rst.perr", perr, 0);
        @(negedge clk);
        rst_ni = 1;
        next_cycle();

        //              m0 m1 gnt rv  g0 g1 sreq addr    rv0 rv1 out
        tbl[0]  = mk(1, 0, 1, 0,  1, 0, 1, 32'h100, 0, 0, 0);
        tbl[1]  = mk(0, 0, 1, 1,  0, 0, 0, 32'h000, 1, 0, 1);
        tbl[2]  = mk(1, 1, 1, 0,  0, 1, 1, 32'h200, 0, 0, 0);
        tbl[3]  = mk(1, 1, 1, 1,  1, 0, 1, 32'h100, 0, 1, 1);
        tbl[4]  = mk(1, 1, 1, 1,  0, 1, 1, 32'h200, 1, 0, 1);
        tbl[5]  = mk(1, 1, 1, 0,  1, 0, 1, 32'h100, 0, 0, 1);
        tbl[6]  = mk(1, 1, 1, 0,  0, 0, 0, 32'h000, 0, 0, 2);
        tbl[7]  = mk(1, 1, 1, 1,  0, 0, 0, 32'h000, 0, 1, 2);
        tbl[8]  = mk(1, 1, 1, 1,  0, 1, 1, 32'h200, 1, 0, 1);
        tbl[9]  = mk(1, 0, 0, 1,  0, 0, 1, 32'h100, 0, 1, 1);
        tbl[10] = mk(1, 1, 0, 0,  0, 0, 1, 32'h100, 0, 0, 0);
        tbl[11] = mk(1, 1, 0, 0,  0, 0, 1, 32'h100, 0, 0, 0);
        tbl[12] = mk(1, 1, 1, 0,  1, 0, 1, 32'h100, 0, 0, 0);
        tbl[13] = mk(0, 1, 1, 0,  0, 1, 1, 32'h200, 0, 0, 1);
        tbl[14] = mk(0, 0, 0, 1,  0, 0, 0, 32'h000, 1, 0, 2);
        tbl[15] = mk(0, 0, 0, 1,  0, 0, 0, 32'h000, 0, 1, 1);
        tbl[16] = mk(0, 1, 0, 0,  0, 0, 1, 32'h200, 0, 0, 0);
        tbl[17] = mk(1, 0, 1, 0,  0, 0, 0, 32'h000, 0, 0, 0);
        tbl[18] = mk(1, 0, 1, 0,  1, 0, 1, 32'h100, 0, 0, 0);
        tbl[19] = mk(0, 0, 0, 1,  0, 0, 0, 32'h000, 1, 0, 1);
        tbl[20] = mk(0, 0, 0, 0,  0, 0, 0, 32'h000, 0, 0, 0);

        for (int i = 0; i < 21; i++) begin
            m0_req = tbl[i].m0; m1_req = tbl[i].m1;
            s_gnt = tbl[i].gnt; s_rvalid = tbl[i].rv;
            s_rdata = 32'hA000 + i; s_err = i[0];
            @(negedge clk);
            chk($sformatf("v%0d.g0", i), m0_gnt, tbl[i].e_g0);
            chk($sformatf("v%0d.g1", i), m1_gnt, tbl[i].e_g1);
            chk($sformatf("v%0d.s_req", i), s_req, tbl[i].e_sreq);
            chk($sformatf("v%0d.s_addr", i), s_addr, tbl[i].e_addr);
            chk($sformatf("v%0d.rv0", i), m0_rvalid, tbl[i].e_rv0);
            chk($sformatf("v%0d.rv1", i), m1_rvalid, tbl[i].e_rv1);
            chk($sformatf("v%0d.rdata0", i), m0_rdata, tbl[i].e_rv0 ? 32'hA000 + i : 0);
            chk($sformatf("v%0d.rdata1", i), m1_rdata, tbl[i].e_rv1 ? 32'hA000 + i : 0);
            chk($sformatf("v%0d.err0", i), m0_err, tbl[i].e_rv0 & i[0]);
            chk($sformatf("v%0d.out", i), outstanding, tbl[i].e_out);
            next_cycle();
        end

        // Stray response with nothing outstanding: dropped, sticky flag.
        idle_inputs();
        s_rvalid = 1; s_rdata = 32'hBAD;
        @(negedge clk);
        chk("stray.rv0", m0_rvalid, 0);
        chk("stray.rv1", m1_rvalid, 0);
        chk("stray.perr_before", perr, 0);
        next_cycle();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("stray.perr%0d", i), perr, 1);
            chk($sformatf("stray.out%0d", i), outstanding, 0);
            next_cycle();
        end

        // Reset with a transaction in flight, then a late response.
        rst_ni = 0;
        #2;
        chk("rst2.perr_clear", perr, 0);
        @(negedge clk);
        rst_ni = 1;
        next_cycle();
        m0_req = 1; s_gnt = 1;
        @(negedge clk);
        chk("mid.g0", m0_gnt, 1);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        chk("mid.out1", outstanding, 1);
        next_cycle();
        rst_ni = 0;
        #2;
        chk("mid.out_flushed", outstanding, 0);
        @(negedge clk);
        rst_ni = 1;
        next_cycle();
        s_rvalid = 1; s_rdata = 32'h1234;
        @(negedge clk);
        chk("late.rv0", m0_rvalid, 0);
        chk("late.rdata0", m0_rdata, 0);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        chk("late.perr", perr, 1);

        // Randomized run against the queue model.
        rst_ni = 0;
        #2;
        chk("rst3.perr", perr, 0);
        @(negedge clk);
        rst_ni = 1;
        q.delete(); ptr_m = 0; hold_m = -1; perr_m = 0;
        pend[0] = 0; pend[1] = 0;
        for (int c = 0; c < 1500; c++) begin
            int          sel, rv_id;
            bit          sreq, acc;
            logic [31:0] rd;
            logic        er;
            next_cycle();
            for (int m = 0; m < 2; m++) begin
                if (!pend[m]) begin
                    if ($urandom_range(0, 99) < 55) begin
                        pend[m] = 1;
                        r_addr[m] = {$urandom_range(0, 32'hFFFF), 2'b00};
                        r_we[m] = $urandom_range(0, 1);
                        r_be[m] = 4'($urandom_range(1, 15));
                        r_wdata[m] = $urandom;
                    end
                end else if ($urandom_range(0, 99) < 3) begin
                    pend[m] = 0;
                end
            end
            m0_req = pend[0]; m0_addr = r_addr[0]; m0_we = r_we[0]; m0_be = r_be[0]; m0_wdata = r_wdata[0];
            m1_req = pend[1]; m1_addr = r_addr[1]; m1_we = r_we[1]; m1_be = r_be[1]; m1_wdata = r_wdata[1];
            s_gnt = ($urandom_range(0, 2) != 0);
            s_rvalid = (q.size() > 0) && ($urandom_range(0, 1) == 1);
            rd = $urandom; er = $urandom_range(0, 1);
            s_rdata = rd; s_err = er;
            @(negedge clk);

            sel = -1;
            if (q.size() < MAXO) begin
                if (hold_m >= 0) begin
                    if (pend[hold_m]) sel = hold_m;
                end else if (pend[0] && pend[1]) begin
                    sel = ptr_m;
                end else if (pend[0]) begin
                    sel = 0;
                end else if (pend[1]) begin
                    sel = 1;
                end
            end
            sreq  = (sel >= 0);
            acc   = sreq && s_gnt;
            rv_id = (s_rvalid && q.size() > 0) ? q[0] : -1;

            chk($sformatf("r%0d.s_req", c), s_req, sreq);
            chk($sformatf("r%0d.g0", c), m0_gnt, acc && sel == 0);
            chk($sformatf("r%0d.g1", c), m1_gnt, acc && sel == 1);
            chk($sformatf("r%0d.s_addr", c), s_addr, sreq ? r_addr[sel] : 0);
            chk($sformatf("r%0d.s_we", c), s_we, sreq ? r_we[sel] : 0);
            chk($sformatf("r%0d.s_be", c), s_be, sreq ? r_be[sel] : 0);
            chk($sformatf("r%0d.s_wdata", c), s_wdata, sreq ? r_wdata[sel] : 0);
            chk($sformatf("r%0d.rv0", c), m0_rvalid, rv_id == 0);
            chk($sformatf("r%0d.rv1", c), m1_rvalid, rv_id == 1);
            chk($sformatf("r%0d.rdata0", c), m0_rdata, (rv_id == 0) ? rd : 0);
            chk($sformatf("r%0d.rdata1", c), m1_rdata, (rv_id == 1) ? rd : 0);
            chk($sformatf("r%0d.err1", c), m1_err, (rv_id == 1) && er);
            chk($sformatf("r%0d.out", c), outstanding, q.size());
            chk($sformatf("r%0d.perr", c), perr, perr_m);

            if (s_rvalid) begin
                if (q.size() > 0) void'(q.pop_front());
                else perr_m = 1;
            end
            if (acc) begin
                q.push_back(sel);
                ptr_m = 1 - sel;
                hold_m = -1;
                pend[sel] = 0;
            end else if (sreq) begin
                hold_m = sel;
            end else begin
                hold_m = -1;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
